arbitro_fila: RTL and testbench
===============================

Name: arbitro_fila

Overview:
- Round-robin arbiter that shares the single write port of the 8-bit fila (carregar_data / data_ent / fila_cheia) among N_REQ producers.
- Grants one producer at a time for a burst of up to RAJADA_MAX beats.
- Muxes the owner's data onto the fila write port and obeys fila_cheia backpressure.
- Sits between the producer blocks and the fila input.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- LARGURA, 8, data width per requester, equal to the fila data width
- RAJADA_MAX, 4, maximum beats per grant (1..15)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  reset: synchronous, active-high
- req  in  N_REQ  per-requester request/valid; held high while that requester has data
- dado_req  in  N_REQ*LARGURA  packed requester data; slice i = bits [i*LARGURA +: LARGURA]
- ultimo  in  N_REQ  per-requester last-beat marker, sampled with that requester's beat
- fila_cheia  in  1  backpressure from the fila; no beat transfers while high
- gnt  out  N_REQ  one-hot registered grant
- dono  out  clog2(N_REQ)  index of current owner
- ocupado  out  1  high while in CONCEDIDO
- carregar_data  out  1  write strobe to the fila
- data_ent  out  LARGURA  write data to the fila

Behaviour:
- Reset, synchronous while rst=1 at posedge:
  - estado=OCIOSO, gnt=0, dono=0, ocupado=0, prio=0, cont=0.
  - carregar_data is forced 0 combinationally whenever rst=1.
  - data_ent=0 whenever estado=OCIOSO.
- State machine, 2 states:
  - OCIOSO:
    - If req==0, stay.
    - Otherwise select the first i with req[i]=1, scanning prio, prio+1, ..., mod N_REQ.
    - Next cycle: estado=CONCEDIDO, dono=i, gnt=one-hot(i), ocupado=1, cont=0.
    - Grant latency is 1 cycle from req seen to gnt high.
    - No beat transfers in OCIOSO.
  - CONCEDIDO:
    - beat = req[dono] & ~fila_cheia.
    - carregar_data = beat, combinational from registered state and current inputs.
    - data_ent = dado_req slice dono, regardless of beat.
    - On beat, cont increments. cont is 4 bits and saturates, never wraps.
    - Release occurs at the clock edge when any of:
      - beat with ultimo[dono]=1;
      - beat with cont+1 == RAJADA_MAX;
      - req[dono]=0, abandon with no beat that cycle.
    - On release: next estado=OCIOSO, gnt=0, ocupado=0, prio=(dono+1) mod N_REQ, cont=0.
    - Exactly one OCIOSO cycle separates consecutive grants.
- Backpressure:
  - fila_cheia=1 in CONCEDIDO: carregar_data=0, cont holds, grant held, no release unless req[dono] drops.
  - fila_cheia is ignored in OCIOSO.
- Fairness: the just-served requester has lowest priority at the next arbitration. With all requesters continuously requesting, the grant sequence is 0,1,2,3,0,...
- Requests from non-owners during CONCEDIDO are ignored; they are evaluated only in OCIOSO.
- ultimo of non-owners is ignored.
- ultimo[dono]=1 with fila_cheia=1 is not a beat; release waits for the actual beat.
- rst asserted mid-burst: the current cycle carries no beat, all state is cleared at the edge, and prio returns to 0.
- The fila is never written unless gnt[dono]=1 and estado=CONCEDIDO.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, carregar_data=0, ocupado=0, data_ent=0. First cycle after rst falls: still OCIOSO. Next: gnt=4'b0001.
- Single burst: req[2]=1, data 0x10,0x11,0x12 with ultimo on 0x12, fila_cheia=0 -> gnt=4'b0100 one cycle after req. carregar_data high 3 consecutive cycles with data_ent 0x10,0x11,0x12. Then gnt=0 and prio=3.
- Burst cap: req[0] held, never ultimo, RAJADA_MAX=4 -> exactly 4 beats, release, one idle cycle, re-grant to 0 only if no other req.
- Round-robin: req=4'b1111 continuous, each requester asserts ultimo on its first beat -> grant order 0,1,2,3,0. Each grant lasts 1 cycle, separated by 1 idle cycle.
- Backpressure: grant to 1, fila_cheia=1 for cycles 2..4 of the burst -> carregar_data=0 in those cycles, cont frozen. Beats resume with unchanged data_ent; total beats delivered = 4.
- Abandon and mid-burst reset:
  - req[3] drops after 1 beat -> release with cont=1, prio=0.
  - Separately, rst pulsed during beat 2 of a burst -> no carregar_data that cycle, gnt=0 next cycle, prio=0.

Source files
------------

// File: rtl/arbitro_fila_if.sv
// Purpose: bundles the producer request/data lines and the fila write port seen by arbitro_fila.
// Latency: none, signal container only.
// Backpressure: fila_cheia travels toward the arbiter; a high level blocks every write strobe.
// Ports: req/dado_req/ultimo come from the producers, fila_cheia from the fila;
//        gnt/dono/ocupado go back to the producers, carregar_data/data_ent go to the fila.
interface arbitro_fila_if #(
  parameter int N_REQ   = 4,
  parameter int LARGURA = 8
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]         req;
  logic [N_REQ*LARGURA-1:0] dado_req;
  logic [N_REQ-1:0]         ultimo;
  logic                     fila_cheia;
  logic [N_REQ-1:0]         gnt;
  logic [IW-1:0]            dono;
  logic                     ocupado;
  logic                     carregar_data;
  logic [LARGURA-1:0]       data_ent;

  // Arbiter side: it owns the fila write port and the grant lines.
  modport master (
    input  req, dado_req, ultimo, fila_cheia,
    output gnt, dono, ocupado, carregar_data, data_ent
  );

  // Producer/fila side.
  modport slave (
    output req, dado_req, ultimo, fila_cheia,
    input  gnt, dono, ocupado, carregar_data, data_ent
  );
endinterface

// File: rtl/arbitro_fila.sv
// Purpose: round-robin arbiter sharing the single fila write port among N_REQ producers, bursts up to RAJADA_MAX beats.
// Latency: grant one cycle after a request is seen in OCIOSO; write strobe/data combinational from the owner's inputs.
// Backpressure: fila_cheia suppresses the write strobe and freezes the beat count; the grant is held meanwhile.
// Ports: clk, rst (sync, active-high); bus = arbitro_fila_if.master carrying req/dado_req/ultimo/fila_cheia in
//        and gnt/dono/ocupado/carregar_data/data_ent out.
module arbitro_fila #(
  parameter int N_REQ      = 4,
  parameter int LARGURA    = 8,
  parameter int RAJADA_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  arbitro_fila_if.master bus
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic {OCIOSO = 1'b0, CONCEDIDO = 1'b1} estado_t;

  estado_t            estado, estado_prox;
  logic [N_REQ-1:0]   gnt_q, gnt_prox;
  logic [IW-1:0]      dono_q, dono_prox;
  logic [IW-1:0]      prio_q, prio_prox;
  logic [3:0]         cont_q, cont_prox;

  logic               sel_ok;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      cand;
  logic               req_dono;
  logic               ult_dono;
  logic [LARGURA-1:0] dado_dono;
  logic               beat;
  logic               libera;
  logic [4:0]         cont_mais1;

  // Rotating-priority pick: first requester found scanning prio, prio+1, ... mod N_REQ.
  always_comb begin
    sel_ok  = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((int'(prio_q) + k) % N_REQ);
      if (!sel_ok && bus.req[cand]) begin
        sel_ok  = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Owner's request, last marker and data, selected with constant slices.
  always_comb begin
    req_dono  = 1'b0;
    ult_dono  = 1'b0;
    dado_dono = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (dono_q == IW'(i)) begin
        req_dono  = bus.req[i];
        ult_dono  = bus.ultimo[i];
        dado_dono = bus.dado_req[i*LARGURA +: LARGURA];
      end
    end
  end

  // Next-state and beat/release decisions.
  always_comb begin
    estado_prox = estado;
    gnt_prox    = gnt_q;
    dono_prox   = dono_q;
    prio_prox   = prio_q;
    cont_prox   = cont_q;
    beat        = 1'b0;
    libera      = 1'b0;
    cont_mais1  = {1'b0, cont_q} + 5'd1;
    case (estado)
      OCIOSO: begin
        if (sel_ok) begin
          estado_prox = CONCEDIDO;
          dono_prox   = sel_idx;
          gnt_prox    = N_REQ'(1) << sel_idx;
          cont_prox   = '0;
        end
      end
      CONCEDIDO: begin
        // A reset cycle never carries a beat, even mid-burst.
        beat   = req_dono & ~bus.fila_cheia & ~rst;
        // Dropping req is an abandon; last/cap releases only count on a real beat.
        libera = ~req_dono | (beat & (ult_dono | (cont_mais1 == 5'(RAJADA_MAX))));
        if (beat && cont_q != 4'hF) begin
          cont_prox = cont_q + 4'd1;
        end
        if (libera) begin
          estado_prox = OCIOSO;
          gnt_prox    = '0;
          prio_prox   = IW'((int'(dono_q) + 1) % N_REQ);
          cont_prox   = '0;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= OCIOSO;
      gnt_q  <= '0;
      dono_q <= '0;
      prio_q <= '0;
      cont_q <= '0;
    end else begin
      estado <= estado_prox;
      gnt_q  <= gnt_prox;
      dono_q <= dono_prox;
      prio_q <= prio_prox;
      cont_q <= cont_prox;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.dono          = dono_q;
  assign bus.ocupado       = (estado == CONCEDIDO);
  assign bus.carregar_data = beat;
  assign bus.data_ent      = (estado == CONCEDIDO) ? dado_dono : '0;
endmodule

// File: tb/tb_arbitro_fila.sv
module tb_arbitro_fila;
  logic clk;
  logic rst;

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] dat;
  } beat_t;

  beat_t sb[$];
  int    total;
  int    bad;

  arbitro_fila_if #(.N_REQ(4), .LARGURA(8)) bus ();

  arbitro_fila #(.N_REQ(4), .LARGURA(8), .RAJADA_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] oh2i(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic set_d(input int i, input logic [7:0] v);
    bus.dado_req[i*8 +: 8] = v;
  endtask

  task automatic push(input logic [1:0] own, input logic [7:0] dat);
    beat_t b;
    b.own = own;
    b.dat = dat;
    sb.push_back(b);
  endtask

  // Checks one cycle at the falling edge, then advances to just after the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] eg, input logic el, input logic [7:0] ed);
    beat_t b;
    logic [3:0] oh;
    @(negedge clk);
    total++;
    assert (bus.gnt === eg) else begin
      bad++; $error("FAIL %s gnt got=%b exp=%b", tag, bus.gnt, eg);
    end
    total++;
    assert (bus.ocupado === (eg != 4'b0)) else begin
      bad++; $error("FAIL %s ocupado got=%b exp=%b", tag, bus.ocupado, (eg != 4'b0));
    end
    total++;
    assert (bus.carregar_data === el) else begin
      bad++; $error("FAIL %s carregar_data got=%b exp=%b", tag, bus.carregar_data, el);
    end
    total++;
    assert (bus.data_ent === ed) else begin
      bad++; $error("FAIL %s data_ent got=%h exp=%h", tag, bus.data_ent, ed);
    end
    if (eg != 4'b0) begin
      total++;
      assert (bus.dono === oh2i(eg)) else begin
        bad++; $error("FAIL %s dono got=%0d exp=%0d", tag, bus.dono, oh2i(eg));
      end
    end
    if (bus.carregar_data === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++; $error("FAIL %s unexpected beat got=%h exp=none", tag, bus.data_ent);
      end
      if (sb.size() > 0) begin
        b  = sb.pop_front();
        oh = 4'b0001 << b.own;
        total++;
        assert (bus.data_ent === b.dat) else begin
          bad++; $error("FAIL %s sb data got=%h exp=%h", tag, bus.data_ent, b.dat);
        end
        total++;
        assert (bus.gnt === oh) else begin
          bad++; $error("FAIL %s sb owner got=%b exp=%b", tag, bus.gnt, oh);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst             = 1'b1;
    bus.req         = 4'b1111;
    bus.ultimo      = 4'b1111;
    bus.fila_cheia  = 1'b0;
    bus.dado_req    = 32'hA3A2A1A0;

    // Reset with every requester asking, then round-robin with single-beat grants.
    push(2'd0, 8'hA0); push(2'd1, 8'hA1); push(2'd2, 8'hA2); push(2'd3, 8'hA3); push(2'd0, 8'hA0);
    cyc("rst0", 4'b0000, 1'b0, 8'h00);
    cyc("rst1", 4'b0000, 1'b0, 8'h00);
    rst = 1'b0;
    cyc("rst_rel", 4'b0000, 1'b0, 8'h00);
    cyc("rr_g0",  4'b0001, 1'b1, 8'hA0);
    cyc("rr_i0",  4'b0000, 1'b0, 8'h00);
    cyc("rr_g1",  4'b0010, 1'b1, 8'hA1);
    cyc("rr_i1",  4'b0000, 1'b0, 8'h00);
    cyc("rr_g2",  4'b0100, 1'b1, 8'hA2);
    cyc("rr_i2",  4'b0000, 1'b0, 8'h00);
    cyc("rr_g3",  4'b1000, 1'b1, 8'hA3);
    cyc("rr_i3",  4'b0000, 1'b0, 8'h00);
    cyc("rr_g0b", 4'b0001, 1'b1, 8'hA0);

    // Single three-beat burst on requester 2, ending on ultimo.
    bus.req = 4'b0100; bus.ultimo = 4'b0000; set_d(2, 8'h10);
    push(2'd2, 8'h10); push(2'd2, 8'h11); push(2'd2, 8'h12);
    cyc("sb_idle", 4'b0000, 1'b0, 8'h00);
    cyc("sb_b0",   4'b0100, 1'b1, 8'h10);
    set_d(2, 8'h11);
    cyc("sb_b1",   4'b0100, 1'b1, 8'h11);
    set_d(2, 8'h12); bus.ultimo = 4'b0100;
    cyc("sb_b2",   4'b0100, 1'b1, 8'h12);
    // prio is now 3: requesters 1 and 3 compete, 3 must win.
    bus.req = 4'b1010; bus.ultimo = 4'b1000; set_d(3, 8'h33);
    push(2'd3, 8'h33);
    cyc("sb_rel",  4'b0000, 1'b0, 8'h00);
    cyc("prio3",   4'b1000, 1'b1, 8'h33);

    // Burst cap: requester 0 never signals ultimo.
    bus.req = 4'b0001; bus.ultimo = 4'b0000; set_d(0, 8'h50);
    push(2'd0, 8'h50); push(2'd0, 8'h51); push(2'd0, 8'h52); push(2'd0, 8'h53);
    cyc("cap_idle", 4'b0000, 1'b0, 8'h00);
    cyc("cap_b0",   4'b0001, 1'b1, 8'h50);
    set_d(0, 8'h51);
    cyc("cap_b1",   4'b0001, 1'b1, 8'h51);
    set_d(0, 8'h52);
    cyc("cap_b2",   4'b0001, 1'b1, 8'h52);
    set_d(0, 8'h53);
    cyc("cap_b3",   4'b0001, 1'b1, 8'h53);
    cyc("cap_rel",  4'b0000, 1'b0, 8'h00);
    // Re-granted to 0, which abandons immediately: no beat.
    bus.req = 4'b0000;
    cyc("cap_regnt", 4'b0001, 1'b0, 8'h53);

    // Backpressure on requester 1: three stalled cycles, ultimo during a stall is no beat.
    bus.req = 4'b0010; set_d(1, 8'h60);
    push(2'd1, 8'h60); push(2'd1, 8'h61); push(2'd1, 8'h62); push(2'd1, 8'h63);
    cyc("bp_idle", 4'b0000, 1'b0, 8'h00);
    cyc("bp_b0",   4'b0010, 1'b1, 8'h60);
    set_d(1, 8'h61); bus.fila_cheia = 1'b1;
    cyc("bp_s1",   4'b0010, 1'b0, 8'h61);
    cyc("bp_s2",   4'b0010, 1'b0, 8'h61);
    bus.ultimo = 4'b0010;
    cyc("bp_s3",   4'b0010, 1'b0, 8'h61);
    bus.ultimo = 4'b0000; bus.fila_cheia = 1'b0;
    cyc("bp_b1",   4'b0010, 1'b1, 8'h61);
    set_d(1, 8'h62);
    cyc("bp_b2",   4'b0010, 1'b1, 8'h62);
    set_d(1, 8'h63);
    cyc("bp_b3",   4'b0010, 1'b1, 8'h63);

    // Abandon: requester 3 drops after one beat, prio must become 0.
    bus.req = 4'b1000; set_d(3, 8'h70);
    push(2'd3, 8'h70);
    cyc("ab_idle", 4'b0000, 1'b0, 8'h00);
    cyc("ab_b0",   4'b1000, 1'b1, 8'h70);
    bus.req = 4'b0000;
    cyc("ab_drop", 4'b1000, 1'b0, 8'h70);
    bus.req = 4'b0110; bus.ultimo = 4'b0110; set_d(1, 8'h81); set_d(2, 8'h92);
    push(2'd1, 8'h81);
    cyc("ab_idle2", 4'b0000, 1'b0, 8'h00);
    cyc("ab_prio0", 4'b0010, 1'b1, 8'h81);

    // Reset pulsed during the second beat of a burst on requester 2.
    bus.req = 4'b0100; bus.ultimo = 4'b0000; set_d(2, 8'h90);
    push(2'd2, 8'h90);
    cyc("rs_idle", 4'b0000, 1'b0, 8'h00);
    cyc("rs_b0",   4'b0100, 1'b1, 8'h90);
    set_d(2, 8'h91); rst = 1'b1;
    cyc("rs_rst",  4'b0100, 1'b0, 8'h91);
    rst = 1'b0; bus.req = 4'b1110; bus.ultimo = 4'b1110; set_d(1, 8'hB1);
    push(2'd1, 8'hB1);
    cyc("rs_after", 4'b0000, 1'b0, 8'h00);
    cyc("rs_prio0", 4'b0010, 1'b1, 8'hB1);
    bus.req = 4'b0000; bus.ultimo = 4'b0000;
    cyc("end_idle", 4'b0000, 1'b0, 8'h00);

    total++;
    assert (sb.size() == 0) else begin
      bad++; $error("FAIL sb_drain left=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
